// File: rtl/mem_stream_reader.sv
// -----------------------------------------------------------------------------
// mem_stream_reader
//
// Reads a burst of consecutive words from a synchronous-read memory and
// presents them as a valid/ready stream. A burst is requested with a one-cycle
// start pulse carrying a base address and a word count. Addresses wrap modulo
// 2**DEPTH. The memory returns data one cycle after the address is presented.
// A 2-entry FIFO absorbs downstream back-pressure. Read issue is throttled so
// that buffered words plus the pending read never exceed the FIFO capacity.
//
// Parameters
//   DEPTH          memory address width (2**DEPTH words)
//   WIDTH          data word width
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   start          one-cycle burst request (honoured only while idle)
//   base_addr      first word address, sampled with an accepted start
//   count          burst length 0..2**DEPTH, sampled with an accepted start
//   mem_read_addr  read address to the memory
//   mem_data       memory read data, valid the cycle after the address
//   out_data       stream data (FIFO head)
//   out_valid      out_data valid
//   out_ready      downstream accepts the word when high with out_valid
//   out_last       head word is the final word of the burst
//   busy           a burst is in progress
//   done           one-cycle pulse after the final word is accepted
// -----------------------------------------------------------------------------
module mem_stream_reader #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DEPTH-1:0] base_addr,
  input  logic [DEPTH:0]   count,
  output logic [DEPTH-1:0] mem_read_addr,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [DEPTH:0]   REM_ONE  = {{DEPTH{1'b0}}, 1'b1};
  localparam logic [DEPTH-1:0] ADDR_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  // Control state
  state_t           state_q,          state_d;
  logic [DEPTH-1:0] addr_q,           addr_d;
  logic [DEPTH-1:0] rd_addr_q,        rd_addr_d;
  logic [DEPTH:0]   remaining_q,      remaining_d;
  logic             in_flight_q,      in_flight_d;
  logic             in_flight_last_q, in_flight_last_d;
  logic [1:0]       fifo_cnt_q,       fifo_cnt_d;
  logic             wr_ptr_q,         wr_ptr_d;
  logic             rd_ptr_q,         rd_ptr_d;
  logic             done_q,           done_d;

  // FIFO storage (data path, not reset; validity tracked by fifo_cnt_q)
  logic [WIDTH-1:0] fifo_data_q [2];
  logic [WIDTH-1:0] fifo_data_d [2];
  logic             fifo_last_q [2];
  logic             fifo_last_d [2];

  logic             pop;
  logic             push;
  logic             issue;
  logic [2:0]       occ_after;
  logic             head_last;

  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign head_last = fifo_last_q[rd_ptr_q];
  assign out_last  = out_valid & head_last;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  assign pop  = out_valid & out_ready;
  // The read issued last cycle returns its data in this cycle.
  assign push = in_flight_q;

  // Occupancy the FIFO would have after this cycle, counting the pending read
  // as already stored. A new read is allowed only if it still fits afterwards.
  assign occ_after = 3'(fifo_cnt_q) + 3'(in_flight_q) - 3'(pop);

  assign issue = (state_q == ST_RUN) && (remaining_q != '0) && (occ_after < 3'd2);

  // The address is visible in the issue cycle itself so the memory returns the
  // word one cycle later; otherwise the last issued address is held.
  assign mem_read_addr = issue ? addr_q : rd_addr_q;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    rd_addr_d        = rd_addr_q;
    remaining_d      = remaining_q;
    in_flight_d      = issue;
    in_flight_last_d = issue && (remaining_q == REM_ONE);
    fifo_cnt_d       = fifo_cnt_q + 2'(push) - 2'(pop);
    wr_ptr_d         = wr_ptr_q ^ push;
    rd_ptr_d         = rd_ptr_q ^ pop;
    done_d           = 1'b0;
    fifo_data_d      = fifo_data_q;
    fifo_last_d      = fifo_last_q;

    if (push) begin
      fifo_data_d[wr_ptr_q] = mem_data;
      fifo_last_d[wr_ptr_q] = in_flight_last_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = count;
          // An empty burst completes immediately without leaving IDLE.
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (issue) begin
          rd_addr_d   = addr_q;
          addr_d      = addr_q + ADDR_ONE;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // All reads are issued; finish when the tagged final word is taken.
        if (pop && head_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      addr_q           <= '0;
      rd_addr_q        <= '0;
      remaining_q      <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
      fifo_cnt_q       <= 2'd0;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      rd_addr_q        <= rd_addr_d;
      remaining_q      <= remaining_d;
      in_flight_q      <= in_flight_d;
      in_flight_last_q <= in_flight_last_d;
      fifo_cnt_q       <= fifo_cnt_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      done_q           <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_last_q <= fifo_last_d;
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
module tb_mem_stream_reader;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int NW    = 1 << DEPTH;

  logic             clk;
  logic             reset;
  logic             start;
  logic [DEPTH-1:0] base_addr;
  logic [DEPTH:0]   count;
  logic [DEPTH-1:0] mem_read_addr;
  logic [WIDTH-1:0] mem_data;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             done;

  mem_stream_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .count(count), .mem_read_addr(mem_read_addr), .mem_data(mem_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model
  logic [WIDTH-1:0] mem_arr [NW];
  always @(posedge clk) mem_data <= mem_arr[mem_read_addr];

  int checks   = 0;
  int failures = 0;

  // Observations of the current cycle (taken at the falling edge)
  logic             s_valid, s_last, s_busy, s_done;
  logic [DEPTH-1:0] s_addr;
  logic [WIDTH:0]   got_q [$];
  logic [WIDTH:0]   exp_q [$];
  int               done_cyc [$];
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] stall_data;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Inputs set before calling apply to this cycle; returns just after the
  // next rising edge.
  task automatic tick();
    @(negedge clk);
    s_valid = out_valid;
    s_last  = out_last;
    s_busy  = busy;
    s_done  = done;
    s_addr  = mem_read_addr;
    if (stall_prev) begin
      checks++;
      if (!out_valid || out_data !== stall_data) begin
        failures++;
        $display("FAIL stall_hold actual=%0d/%0d required=1/%0d", out_valid, out_data, stall_data);
      end
    end
    if (out_valid && out_ready) got_q.push_back({out_last, out_data});
    stall_prev = out_valid && !out_ready && !reset;
    stall_data = out_data;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int base;  int cnt;  bit rnd;
    int s2_at; int s2_base; int s2_cnt;
    int exp_first; int exp_done; int exp_ndone;
  } vec_t;

  // Reference model: a burst delivers mem[(base+k) mod 2**DEPTH], k=0..cnt-1.
  task automatic add_burst(input int b, input int c);
    for (int k = 0; k < c; k++)
      exp_q.push_back({(k == c - 1) ? 1'b1 : 1'b0, mem_arr[(b + k) % NW]});
  endtask

  // Cycle (relative to its start) at which a burst leaves the busy period,
  // assuming out_ready held high.
  function automatic int idle_at(input int c);
    return (c == 0) ? 1 : c + 3;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int  first = -1;
    bit  any_valid = 0, any_busy = 0, finished = 0;
    int  tail = 0;
    got_q.delete(); exp_q.delete(); done_cyc.delete();
    base_addr = DEPTH'(v.base); count = (DEPTH+1)'(v.cnt); start = 1'b1;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (cyc > 0) start = 1'b0;
      if (cyc == v.s2_at) begin
        start = 1'b1; base_addr = DEPTH'(v.s2_base); count = (DEPTH+1)'(v.s2_cnt);
      end
      out_ready = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      if (s_valid && first < 0) first = cyc;
      any_valid |= s_valid;
      any_busy  |= s_busy;
      if (s_done) begin
        done_cyc.push_back(cyc);
        check({tag, "_busy_at_done"}, s_busy, 0);
      end
      if (done_cyc.size() >= v.exp_ndone && cyc > v.s2_at) begin
        tail++;
        if (tail > 3) finished = 1;
      end
    end
    start = 1'b0;
    if (!finished) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=%0d dones required=%0d", tag, done_cyc.size(), v.exp_ndone);
    end
    add_burst(v.base, v.cnt);
    if (v.s2_at >= 0 && v.s2_at >= idle_at(v.cnt)) add_burst(v.s2_base, v.s2_cnt);
    check({tag, "_ndone"}, done_cyc.size(), v.exp_ndone);
    if (v.exp_done >= 0 && done_cyc.size() > 0)
      check({tag, "_done_cycle"}, done_cyc[done_cyc.size() - 1], v.exp_done);
    if (v.exp_first >= 0) check({tag, "_first_valid"}, first, v.exp_first);
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("%s_word%0d", tag, k), got_q[k], exp_q[k]);
    if (exp_q.size() == 0) begin
      check({tag, "_no_valid"}, any_valid, 0);
      check({tag, "_no_busy"}, any_busy, 0);
    end
  endtask

  vec_t tbl [9];
  vec_t rv;

  initial begin
    tbl[0] = '{4,   5,   0, -1, 0,   0, 3, 8,   1};
    tbl[1] = '{254, 4,   0, -1, 0,   0, 3, 7,   1};
    tbl[2] = '{0,   0,   0, -1, 0,   0, -1, 1,  1};
    tbl[3] = '{250, 16,  1, -1, 0,   0, -1, -1, 1};
    tbl[4] = '{30,  8,   0, 2,  200, 3, 3, 11,  1};
    tbl[5] = '{4,   2,   0, 5,  60,  3, 3, 11,  2};
    tbl[6] = '{7,   256, 0, -1, 0,   0, 3, 259, 1};
    tbl[7] = '{9,   1,   0, -1, 0,   0, 3, 4,   1};
    tbl[8] = '{0,   0,   0, 1,  77,  2, 4, 6,   2};

    for (int i = 0; i < NW; i++) mem_arr[i] = WIDTH'(i);
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_valid", s_valid, 0);
    check("rst_last", s_last, 0);
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    check("rst_addr", s_addr, 0);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset after 3 of 8 words delivered
    got_q.delete();
    base_addr = 8'd10; count = 9'd8; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    check("midrst_delivered", got_q.size(), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("midrst_valid", s_valid, 0);
    check("midrst_busy", s_busy, 0);
    check("midrst_last", s_last, 0);
    check("midrst_addr", s_addr, 0);
    begin
      bit seen_done = s_done, seen_valid = s_valid;
      for (int c = 0; c < 8; c++) begin
        tick(); seen_done |= s_done; seen_valid |= s_valid;
      end
      check("midrst_no_done", seen_done, 0);
      check("midrst_no_valid", seen_valid, 0);
    end
    rv = '{100, 6, 0, -1, 0, 0, 3, 9, 1};
    run_vec(rv, "after_rst");

    // Reset wins over a simultaneous start
    reset = 1'b1; start = 1'b1; base_addr = 8'd50; count = 9'd4;
    tick();
    reset = 1'b0; start = 1'b0;
    begin
      bit seen = 0;
      for (int c = 0; c < 6; c++) begin
        tick(); seen |= s_busy | s_valid | s_done;
      end
      check("rst_over_start_idle", seen, 0);
    end

    // Randomized bursts against the reference model
    for (int i = 0; i < NW; i++) mem_arr[i] = WIDTH'($urandom);
    for (int n = 0; n < 8; n++) begin
      rv = '{int'($urandom_range(0, NW - 1)), int'($urandom_range(0, 40)), 1,
             -1, 0, 0, -1, -1, 1};
      run_vec(rv, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
